// File: rtl/mesh_terminal_node.sv
// Mesh terminal endpoint: feeds a local TX FIFO into the router and
// captures router packets into a local RX holding register.
module mesh_terminal_node #(
  parameter int ROWS = 4,
  parameter int COLUMS = 4,
  parameter int pckg_sz = 32,
  parameter int fifo_depth = 4,
  parameter logic [7:0] bdcst = 8'hFF,
  parameter logic [7:0] MY_ID = 8'h00
) (
  input  logic clk,
  input  logic reset,
  input  logic tx_valid,
  input  logic [pckg_sz-1:0] tx_data,
  output logic tx_ready,
  output logic pndng_i_in,
  output logic [pckg_sz-1:0] data_out_i_in,
  input  logic pop,
  input  logic pndng,
  input  logic [pckg_sz-1:0] data_out,
  output logic popin,
  output logic rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  output logic rx_misroute,
  input  logic rx_ready,
  output logic [15:0] tx_cnt,
  output logic [15:0] rx_cnt,
  output logic [15:0] misroute_cnt,
  output logic err_pop_empty
);

  localparam int AW = $clog2(fifo_depth);
  localparam logic [AW:0] DEPTH = (AW+1)'(fifo_depth);

  if (pckg_sz < 16 || fifo_depth < 2 ||
      (fifo_depth & (fifo_depth - 1)) != 0 ||
      ROWS < 1 || ROWS > 16 ||
      COLUMS < 1 || COLUMS > 16) begin : g_bad_cfg
    $error("mesh_terminal_node: bad parameters");
  end

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // TX FIFO
  logic [pckg_sz-1:0] mem [fifo_depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0] count;
  logic full;
  logic empty;
  logic push;
  logic do_pop;

  assign full = (count == DEPTH);
  assign empty = (count == '0);
  assign push = tx_valid && !full;
  assign do_pop = pop && !empty;
  assign tx_ready = !full;
  assign pndng_i_in = !empty;
  assign data_out_i_in = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      tx_cnt <= '0;
      err_pop_empty <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        tx_cnt <= sat_inc(tx_cnt);
      end
      case ({push, do_pop})
        2'b10: count <= count + 1'b1;
        2'b01: count <= count - 1'b1;
        default: ;
      endcase
      if (pop && empty) begin
        err_pop_empty <= 1'b1;
      end
    end
  end

  // RX side: one capture, then a dead cycle so a stale pndng is skipped
  typedef enum logic [1:0] {
    IDLE,
    ACK,
    GAP
  } rx_state_t;

  rx_state_t state;
  logic [7:0] dest;
  logic cap;
  logic mis;

  assign dest = data_out[pckg_sz-9 -: 8];
  assign mis = (dest != MY_ID) && (dest != bdcst);
  assign cap = (state == IDLE) && pndng &&
               (!rx_valid || rx_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      popin <= 1'b0;
      rx_valid <= 1'b0;
      rx_data <= '0;
      rx_misroute <= 1'b0;
      rx_cnt <= '0;
      misroute_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cap) begin
            state <= ACK;
            popin <= 1'b1;
          end
        end
        ACK: begin
          state <= GAP;
          popin <= 1'b0;
        end
        GAP: state <= IDLE;
        default: begin
          state <= IDLE;
          popin <= 1'b0;
        end
      endcase
      if (cap) begin
        rx_valid <= 1'b1;
        rx_data <= data_out;
        rx_misroute <= mis;
        rx_cnt <= sat_inc(rx_cnt);
        if (mis) begin
          misroute_cnt <= sat_inc(misroute_cnt);
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mesh_terminal_node.md
# mesh_terminal_node

Synthesizable terminal endpoint that attaches to one edge terminal of the mesh router and speaks the far side of both terminal handshakes. It sources packets into the router (pndng_i_in / data_out_i_in, consumed by router pop) from a local TX FIFO. It sinks packets from the router (pndng / data_out) by issuing popin and presenting them on a local RX port. One instance per terminal (ROWS*2+COLUMS*2 instances); it replaces the behavioural bench driver in system-level runs.

## Interface
- ROWS, 4, mesh rows; sets the row-field range
- COLUMS, 4, mesh columns; sets the column-field range
- pckg_sz, 32, packet width in bits; minimum 16
- fifo_depth, 4, TX FIFO entries; power of two, ≥2
- bdcst, 8'hFF, broadcast destination ID
- MY_ID, 8'h00, this terminal's ID: {row[3:0], col[3:0]}
- clk  input  1  clock; all logic on posedge
- reset  input  1  asynchronous, active-high reset
- tx_valid  input  1  local packet offered
- tx_data  input  pckg_sz  local packet
- tx_ready  output  1  TX FIFO not full
- pndng_i_in  output  1  packet pending toward the router
- data_out_i_in  output  pckg_sz  packet toward the router (TX FIFO head)
- pop  input  1  router consumes the head
- pndng  input  1  router has a packet for this terminal
- data_out  input  pckg_sz  router packet
- popin  output  1  terminal consumes the router packet
- rx_valid  output  1  received packet held
- rx_data  output  pckg_sz  received packet
- rx_misroute  output  1  the held packet's destination is neither MY_ID nor bdcst
- rx_ready  input  1  local sink accepts the held packet
- tx_cnt, rx_cnt, misroute_cnt  output  16 each  saturating counters
- err_pop_empty  output  1  sticky: pop arrived while pndng_i_in=0

## Operation
- Destination field: data[pckg_sz-9 : pckg_sz-16]. The top byte (next-jump) is ignored.
- TX FIFO, circular, depth fifo_depth:
  - Push when tx_valid && tx_ready. tx_ready = !full.
  - pndng_i_in = !empty. data_out_i_in = head entry, registered.
  - Pop head when pop && !empty. A push and pop in the same cycle are both honoured; when full, only the pop occurs, since tx_ready=0.
  - The head changes only on a pop, so data is stable until pop.
  - pop while empty: ignored; err_pop_empty set until reset.
  - tx_cnt increments on every accepted router pop.
- RX FSM, states IDLE, ACK, GAP:
  - IDLE → ACK when pndng && (!rx_valid || rx_ready). On that edge: rx_data ← data_out, rx_valid ← 1, rx_misroute computed, popin ← 1.
  - ACK → GAP unconditionally; popin ← 0.
  - GAP → IDLE unconditionally. pndng is ignored in GAP so a stale pndng is never re-consumed.
  - popin is high for exactly one cycle per packet and only while pndng=1.
- RX holding register:
  - rx_valid clears on rx_valid && rx_ready unless a new capture occurs on the same edge; a capture wins.
  - rx_cnt increments per capture. misroute_cnt increments when the captured packet is misrouted.
  - A misrouted packet is still delivered.
- Counters saturate at 16'hFFFF.

## Timing
- Reset (asynchronous, immediate) drives:
  - tx_ready=1, pndng_i_in=0, data_out_i_in=0
  - popin=0, rx_valid=0, rx_data=0, rx_misroute=0
  - all counters 0, err_pop_empty=0
  - FSM=IDLE, FIFO empty
  - Reset mid-transfer drops all FIFO and RX contents. No popin is issued after reset asserts.
- TX latency: push at edge N → pndng_i_in=1 from cycle N+1 (empty FIFO). Router pop at edge M → next head or pndng_i_in=0 in cycle M+1.
- RX: pndng seen in cycle N (IDLE, space free) → rx_valid and popin high in N+1 → popin low in N+2 (GAP) → IDLE in N+3.
  - Maximum RX rate: 1 packet per 3 cycles.
- Back-pressure: with rx_valid=1 and rx_ready=0, popin is never raised and the router packet stays pending.
- Full FIFO: tx_ready=0 in the same cycle count reaches fifo_depth. It returns to 1 the cycle after a pop.

## Test plan
- Reset, then push 0xA1000001..0xA1000004 back to back (fifo_depth=4) → tx_ready=0 after the 4th. pndng_i_in=1 with data_out_i_in=0xA1000001, held stable until pop. Four pops → words emerge in order, tx_cnt=4, pndng_i_in=0.
- pop with the FIFO empty → no state change, err_pop_empty=1 persists until reset.
- Router presents 0x00000000 (dest 0x00 = MY_ID) with pndng=1 at cycle 10 → popin=1 only in cycle 11, rx_data=0x00000000, rx_valid=1, rx_misroute=0, rx_cnt=1.
- Packets with dest 0xFF and dest 0x23 → both delivered. rx_misroute=0 then 1; misroute_cnt=1.
- Hold rx_ready=0 with rx_valid=1 while pndng=1 for 20 cycles → popin stays 0. Raise rx_ready → capture and popin one cycle later.
- Assert reset while the FIFO holds 2 entries and the FSM is in ACK → all outputs return to reset values immediately, without waiting for a clock edge.
